mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single downstream memory port between the core's three memory requesters: instruction read, data read and data write. It sits between the core's INST_*/DATA_* ports and the MMU/bus side. It serialises requests with a fixed priority and returns read responses to the correct requester. It also generates the core's MEM_WAIT stall and drops in-flight instruction fetches on pipeline flush.

## Interface
Parameters: none; all addresses and data are 32 bits.

- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- FLUSH  in  1  pipeline flush (jump taken); cancels instruction fetch
- INST_RDEN  in  1  instruction read request
- INST_RIADDR  in  32  instruction read address
- INST_ROADDR  out  32  address of returned instruction word
- INST_RVALID  out  1  instruction response valid (1-cycle pulse)
- INST_RDATA  out  32  instruction word
- DATA_RDEN  in  1  data read request
- DATA_RIADDR  in  32  data read address
- DATA_ROADDR  out  32  address of returned data word
- DATA_RVALID  out  1  data response valid (1-cycle pulse)
- DATA_RDATA  out  32  data word
- DATA_WREN  in  1  data write request
- DATA_WADDR  in  32  data write address
- DATA_WDATA  in  32  data write word
- MEM_WAIT  out  1  core stall request
- MEM_REQ  out  1  downstream request, held until MEM_ACK
- MEM_WE  out  1  downstream write (1) / read (0)
- MEM_ADDR  out  32  downstream address
- MEM_WDATA  out  32  downstream write data
- MEM_ACK  in  1  downstream completion, 1-cycle pulse; read data valid with it
- MEM_RDATA  in  32  downstream read data

## Operation
- **Pending slots.** There are three slots: W, D and I. Each holds a pend bit and the captured address; W also holds the captured write data.
  - A slot captures when its enable is high and its pend bit is 0.
  - While its pend bit is 1, that requester's enable is ignored. The core holds the same request while stalled.
- **Arbiter FSM.** Two states, IDLE and BUSY, plus a 2-bit owner register.
  - In IDLE, the arbiter picks the highest-priority candidate among pend bits and this cycle's capturing enables.
  - Priority is W > D > I.
  - At the edge it goes to BUSY: MEM_REQ=1, MEM_WE/MEM_ADDR/MEM_WDATA are loaded from the winner, and owner is set.
  - A winner that is a same-cycle enable is captured and issued at the same edge, with its pend bit set.
- **BUSY.** MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA are held stable until MEM_ACK.
  - On ACK the FSM returns to IDLE, MEM_REQ=0, and the owner's pend bit clears.
  - A read ACK registers MEM_RDATA and the slot address into the owner's RDATA/ROADDR and pulses RVALID for 1 cycle.
  - A write ACK produces no response.
- **MEM_ACK in IDLE** is ignored.
- **FLUSH:**
  - A pending, unissued I slot is cleared.
  - If I is in flight, a cancel flag is set; on its ACK no INST_RVALID is produced. Cancel clears on that ACK.
  - D and W slots are unaffected.
  - An INST_RDEN in the FLUSH cycle is ignored.
- **MEM_WAIT** = BUSY | (any pend bit). It is combinational from registers only, with no input-to-output path.
- **Reset values:** all outputs 0, FSM IDLE, pend bits 0, cancel 0. Reset asserted mid-transaction drops MEM_REQ immediately. A later stray MEM_ACK is ignored (IDLE).

## Timing
- **Zero-wait memory (ACK in first REQ cycle), single read.** EN in cycle 0, MEM_REQ in cycle 1, RVALID in cycle 2. Latency is 2 cycles.
- **MEM_WAIT for that read.** It is 0 in cycle 0, 1 in cycle 1, and 0 in cycle 2 (the RVALID cycle).
- **N memory wait cycles** add N cycles to the latency.
- **Back-to-back grants.** A new grant can be issued in the IDLE cycle right after ACK, so a request is issued on every second cycle at most.
- **Simultaneous enables.** All enabled slots are captured in the same cycle. They issue in priority order, one transaction each.
- **RVALID pulses** for INST and DATA never overlap.

## Test plan
- **Single instruction fetch, zero-wait.**
  - Stimulus: INST_RDEN=1, INST_RIADDR=0x100 in cycle 0; memory ACKs in cycle 1 with 0x00000013.
  - Required: MEM_REQ=1, MEM_WE=0, MEM_ADDR=0x100 in cycle 1. INST_RVALID=1, INST_ROADDR=0x100, INST_RDATA=0x13 in cycle 2. MEM_WAIT=1 only in cycle 1.
- **Three-way contention.**
  - Stimulus: INST_RDEN (0x200), DATA_RDEN (0x1000) and DATA_WREN (0x1004, 0xDEADBEEF) all in cycle 0; zero-wait memory.
  - Required: issue order is write 0x1004, then read 0x1000, then read 0x200, in cycles 1, 3 and 5. DATA_RVALID in cycle 4, INST_RVALID in cycle 6. MEM_WAIT is held until cycle 6.
- **Held request under wait states.**
  - Stimulus: ACK delayed 3 cycles; INST_RDEN held high throughout.
  - Required: exactly one MEM_REQ transaction, MEM_ADDR stable across 4 REQ cycles, and one INST_RVALID.
- **Flush of in-flight fetch.**
  - Stimulus: FLUSH asserted in a cycle while fetch 0x300 is BUSY.
  - Required: ACK then gives no INST_RVALID. A new fetch 0x400 issued after that completes normally.
- **Reset mid-transaction.**
  - Stimulus: RST low while BUSY.
  - Required: MEM_REQ=0 and MEM_WAIT=0 immediately. A MEM_ACK after RST deasserts causes no RVALID.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one downstream memory port between the core's instruction
//            read, data read and data write requesters. Requests are captured
//            into pending slots, issued one at a time with fixed priority
//            W > D > I, and read responses are routed back to the requester.
//            Also generates the core stall (MEM_WAIT) and drops instruction
//            fetches on pipeline flush.
// Ports    : CLK, RST (async, active-low), FLUSH
//            INST_RDEN/INST_RIADDR -> INST_RVALID/INST_ROADDR/INST_RDATA
//            DATA_RDEN/DATA_RIADDR -> DATA_RVALID/DATA_ROADDR/DATA_RDATA
//            DATA_WREN/DATA_WADDR/DATA_WDATA
//            MEM_WAIT (stall), MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA,
//            MEM_ACK/MEM_RDATA
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0] OWN_W = 2'd0;
  localparam logic [1:0] OWN_D = 2'd1;
  localparam logic [1:0] OWN_I = 2'd2;

  state_t      state, state_nx;
  logic [1:0]  owner, owner_nx;
  logic        pend_w, pend_d, pend_i;
  logic        pend_w_nx, pend_d_nx, pend_i_nx;
  logic [31:0] addr_w, addr_d, addr_i, wdata_w;
  logic [31:0] addr_w_nx, addr_d_nx, addr_i_nx, wdata_w_nx;
  logic        cancel, cancel_nx;

  logic        mem_req_nx, mem_we_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic        inst_rvalid_nx, data_rvalid_nx;
  logic [31:0] inst_rdata_nx, inst_roaddr_nx, data_rdata_nx, data_roaddr_nx;

  logic        cap_w, cap_d, cap_i, i_inflight;

  // Stall depends only on registered state so there is no input-to-output path.
  assign MEM_WAIT = (state == BUSY) | pend_w | pend_d | pend_i;

  always_comb begin
    cap_w      = DATA_WREN & ~pend_w;
    cap_d      = DATA_RDEN & ~pend_d;
    // A fetch request arriving with FLUSH belongs to the discarded path.
    cap_i      = INST_RDEN & ~pend_i & ~FLUSH;
    i_inflight = (state == BUSY) && (owner == OWN_I);

    state_nx       = state;
    owner_nx       = owner;
    pend_w_nx      = pend_w;
    pend_d_nx      = pend_d;
    pend_i_nx      = pend_i;
    addr_w_nx      = addr_w;
    addr_d_nx      = addr_d;
    addr_i_nx      = addr_i;
    wdata_w_nx     = wdata_w;
    cancel_nx      = cancel;
    mem_req_nx     = MEM_REQ;
    mem_we_nx      = MEM_WE;
    mem_addr_nx    = MEM_ADDR;
    mem_wdata_nx   = MEM_WDATA;
    inst_rvalid_nx = 1'b0;
    data_rvalid_nx = 1'b0;
    inst_rdata_nx  = INST_RDATA;
    inst_roaddr_nx = INST_ROADDR;
    data_rdata_nx  = DATA_RDATA;
    data_roaddr_nx = DATA_ROADDR;

    if (cap_w) begin
      pend_w_nx  = 1'b1;
      addr_w_nx  = DATA_WADDR;
      wdata_w_nx = DATA_WDATA;
    end
    if (cap_d) begin
      pend_d_nx = 1'b1;
      addr_d_nx = DATA_RIADDR;
    end
    if (cap_i) begin
      pend_i_nx = 1'b1;
      addr_i_nx = INST_RIADDR;
    end

    // An issued fetch cannot be withdrawn from the bus, so only its response
    // is suppressed; an unissued one is simply forgotten.
    if (FLUSH) begin
      if (i_inflight) begin
        if (!MEM_ACK) cancel_nx = 1'b1;
      end else begin
        pend_i_nx = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        // The *_nx slot view already merges this cycle's captures, so a
        // same-cycle request can win and issue at this edge.
        if (pend_w_nx) begin
          state_nx     = BUSY;
          owner_nx     = OWN_W;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b1;
          mem_addr_nx  = addr_w_nx;
          mem_wdata_nx = wdata_w_nx;
        end else if (pend_d_nx) begin
          state_nx     = BUSY;
          owner_nx     = OWN_D;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = addr_d_nx;
          mem_wdata_nx = 32'd0;
        end else if (pend_i_nx) begin
          state_nx     = BUSY;
          owner_nx     = OWN_I;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = addr_i_nx;
          mem_wdata_nx = 32'd0;
        end
      end
      BUSY: begin
        if (MEM_ACK) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          case (owner)
            OWN_W: pend_w_nx = 1'b0;
            OWN_D: begin
              pend_d_nx      = 1'b0;
              data_rvalid_nx = 1'b1;
              data_rdata_nx  = MEM_RDATA;
              data_roaddr_nx = addr_d;
            end
            OWN_I: begin
              pend_i_nx = 1'b0;
              cancel_nx = 1'b0;
              if (!cancel && !FLUSH) begin
                inst_rvalid_nx = 1'b1;
                inst_rdata_nx  = MEM_RDATA;
                inst_roaddr_nx = addr_i;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      owner       <= OWN_W;
      pend_w      <= 1'b0;
      pend_d      <= 1'b0;
      pend_i      <= 1'b0;
      addr_w      <= 32'd0;
      addr_d      <= 32'd0;
      addr_i      <= 32'd0;
      wdata_w     <= 32'd0;
      cancel      <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= 32'd0;
      MEM_WDATA   <= 32'd0;
      INST_RVALID <= 1'b0;
      INST_RDATA  <= 32'd0;
      INST_ROADDR <= 32'd0;
      DATA_RVALID <= 1'b0;
      DATA_RDATA  <= 32'd0;
      DATA_ROADDR <= 32'd0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      pend_w      <= pend_w_nx;
      pend_d      <= pend_d_nx;
      pend_i      <= pend_i_nx;
      addr_w      <= addr_w_nx;
      addr_d      <= addr_d_nx;
      addr_i      <= addr_i_nx;
      wdata_w     <= wdata_w_nx;
      cancel      <= cancel_nx;
      MEM_REQ     <= mem_req_nx;
      MEM_WE      <= mem_we_nx;
      MEM_ADDR    <= mem_addr_nx;
      MEM_WDATA   <= mem_wdata_nx;
      INST_RVALID <= inst_rvalid_nx;
      INST_RDATA  <= inst_rdata_nx;
      INST_ROADDR <= inst_roaddr_nx;
      DATA_RVALID <= data_rvalid_nx;
      DATA_RDATA  <= data_rdata_nx;
      DATA_ROADDR <= data_roaddr_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a slot/queue level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        INST_RDEN = 1'b0;
  logic [31:0] INST_RIADDR = 32'd0;
  logic [31:0] INST_ROADDR;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        DATA_RDEN = 1'b0;
  logic [31:0] DATA_RIADDR = 32'd0;
  logic [31:0] DATA_ROADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;
  logic        DATA_WREN = 1'b0;
  logic [31:0] DATA_WADDR = 32'd0;
  logic [31:0] DATA_WDATA = 32'd0;
  logic        MEM_WAIT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = 32'd0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
    .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_delay   = 0;
  int          req_age     = 0;
  bit          rand_mem    = 1'b0;
  bit          stray       = 1'b0;
  bit          force_ack   = 1'b0;
  logic [31:0] fixed_rdata = 32'd0;

  initial forever begin
    @(negedge CLK);
    #2;
    MEM_ACK = 1'b0;
    if (force_ack) begin
      MEM_ACK   = 1'b1;
      MEM_RDATA = 32'hBAD0BAD0;
    end else if (MEM_REQ) begin
      if (req_age >= mem_delay) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = rand_mem ? $urandom : fixed_rdata;
        req_age   = 0;
        if (rand_mem) mem_delay = $urandom_range(0, 3);
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
      if (stray && $urandom_range(0, 7) == 0) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // Slots indexed by priority: 0 = write, 1 = data read, 2 = instruction read.
  bit          m_pend[3];
  logic [31:0] m_addr[3];
  logic [31:0] m_wd;
  bit          m_busy;
  int          m_own;
  bit          m_cancel;
  logic        e_req, e_we, e_iv, e_dv;
  logic [31:0] e_addr, e_wdata, e_ird, e_iro, e_drd, e_dro;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 1'b0;
      m_addr[k] = 32'd0;
    end
    m_wd = 0; m_busy = 0; m_own = 0; m_cancel = 0;
    e_req = 0; e_we = 0; e_iv = 0; e_dv = 0;
    e_addr = 0; e_wdata = 0; e_ird = 0; e_iro = 0; e_drd = 0; e_dro = 0;
  endtask

  task automatic model_step();
    bit          en[3];
    bit          cap[3];
    logic [31:0] ain[3];
    bit          done, was_busy, found;
    en[0] = DATA_WREN;  ain[0] = DATA_WADDR;
    en[1] = DATA_RDEN;  ain[1] = DATA_RIADDR;
    en[2] = INST_RDEN && !FLUSH; ain[2] = INST_RIADDR;
    for (int k = 0; k < 3; k++) cap[k] = en[k] && !m_pend[k];
    was_busy = m_busy;
    done     = m_busy && MEM_ACK;
    e_iv = 0;
    e_dv = 0;
    if (FLUSH) begin
      if (m_busy && m_own == 2) begin
        if (!done) m_cancel = 1;
      end else begin
        m_pend[2] = 0;
      end
    end
    if (done) begin
      if (m_own == 1) begin
        e_dv = 1; e_drd = MEM_RDATA; e_dro = m_addr[1];
      end else if (m_own == 2) begin
        if (!m_cancel && !FLUSH) begin
          e_iv = 1; e_ird = MEM_RDATA; e_iro = m_addr[2];
        end
        m_cancel = 0;
      end
      m_pend[m_own] = 0;
      m_busy = 0;
      e_req  = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (cap[k]) begin
        m_pend[k] = 1;
        m_addr[k] = ain[k];
        if (k == 0) m_wd = DATA_WDATA;
      end
    end
    if (!was_busy) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        if (!found && m_pend[k]) begin
          found   = 1;
          m_busy  = 1;
          m_own   = k;
          e_req   = 1;
          e_we    = (k == 0);
          e_addr  = m_addr[k];
          e_wdata = (k == 0) ? m_wd : 32'd0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (RST && chk_on) begin
      cmp("mem_req", MEM_REQ, e_req);
      if (e_req) begin
        cmp("mem_we", MEM_WE, e_we);
        cmp("mem_addr", MEM_ADDR, e_addr);
        if (e_we) cmp("mem_wdata", MEM_WDATA, e_wdata);
      end
      cmp("mem_wait", MEM_WAIT, m_busy || m_pend[0] || m_pend[1] || m_pend[2]);
      cmp("inst_rvalid", INST_RVALID, e_iv);
      if (e_iv) begin
        cmp("inst_rdata", INST_RDATA, e_ird);
        cmp("inst_roaddr", INST_ROADDR, e_iro);
      end
      cmp("data_rvalid", DATA_RVALID, e_dv);
      if (e_dv) begin
        cmp("data_rdata", DATA_RDATA, e_drd);
        cmp("data_roaddr", DATA_ROADDR, e_dro);
      end
      cmp("rvalid_overlap", INST_RVALID & DATA_RVALID, 1'b0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  logic        r_req[8], r_we[8], r_iv[8], r_dv[8], r_wt[8];
  logic [31:0] r_addr[8], r_wd[8];
  int          n_req, n_rise, n_iv, n_bad;
  logic        prev_req;

  initial begin
    repeat (3) @(negedge CLK);
    cmp("rst_mem_req", MEM_REQ, 0);
    cmp("rst_mem_wait", MEM_WAIT, 0);
    cmp("rst_inst_rvalid", INST_RVALID, 0);
    cmp("rst_data_rvalid", DATA_RVALID, 0);
    cmp("rst_mem_addr", MEM_ADDR, 0);
    #2 RST = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge CLK);

    // Single fetch, zero-wait
    mem_delay = 0; fixed_rdata = 32'h00000013;
    @(negedge CLK);
    cmp("t1_wait_c0", MEM_WAIT, 0);
    #2 INST_RDEN = 1; INST_RIADDR = 32'h100;
    @(negedge CLK);
    cmp("t1_req_c1", MEM_REQ, 1);
    cmp("t1_we_c1", MEM_WE, 0);
    cmp("t1_addr_c1", MEM_ADDR, 32'h100);
    cmp("t1_wait_c1", MEM_WAIT, 1);
    #2 INST_RDEN = 0;
    @(negedge CLK);
    cmp("t1_ivalid_c2", INST_RVALID, 1);
    cmp("t1_iroaddr_c2", INST_ROADDR, 32'h100);
    cmp("t1_irdata_c2", INST_RDATA, 32'h13);
    cmp("t1_wait_c2", MEM_WAIT, 0);
    cmp("t1_model_iroaddr", e_iro, 32'h100);
    cmp("t1_model_irdata", e_ird, 32'h13);
    repeat (2) @(negedge CLK);

    // Three-way contention
    fixed_rdata = 32'hCAFE0001;
    #2;
    INST_RDEN = 1; INST_RIADDR = 32'h200;
    DATA_RDEN = 1; DATA_RIADDR = 32'h1000;
    DATA_WREN = 1; DATA_WADDR = 32'h1004; DATA_WDATA = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      r_req[c] = MEM_REQ; r_we[c] = MEM_WE; r_addr[c] = MEM_ADDR; r_wd[c] = MEM_WDATA;
      r_iv[c] = INST_RVALID; r_dv[c] = DATA_RVALID; r_wt[c] = MEM_WAIT;
      if (c == 1) begin
        cmp("t2_model_addr_c1", e_addr, 32'h1004);
        #2; INST_RDEN = 0; DATA_RDEN = 0; DATA_WREN = 0;
      end
    end
    cmp("t2_req_c1", r_req[1], 1);
    cmp("t2_we_c1", r_we[1], 1);
    cmp("t2_addr_c1", r_addr[1], 32'h1004);
    cmp("t2_wdata_c1", r_wd[1], 32'hDEADBEEF);
    cmp("t2_req_c2", r_req[2], 0);
    cmp("t2_req_c3", r_req[3], 1);
    cmp("t2_we_c3", r_we[3], 0);
    cmp("t2_addr_c3", r_addr[3], 32'h1000);
    cmp("t2_dvalid_c4", r_dv[4], 1);
    cmp("t2_req_c5", r_req[5], 1);
    cmp("t2_addr_c5", r_addr[5], 32'h200);
    cmp("t2_ivalid_c6", r_iv[6], 1);
    cmp("t2_wait_c5", r_wt[5], 1);
    cmp("t2_wait_c6", r_wt[6], 0);
    repeat (2) @(negedge CLK);

    // Held request under three wait states
    mem_delay = 3;
    #2 INST_RDEN = 1; INST_RIADDR = 32'h500;
    n_req = 0; n_rise = 0; n_iv = 0; n_bad = 0; prev_req = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (MEM_REQ) n_req++;
      if (MEM_REQ && !prev_req) n_rise++;
      if (MEM_REQ && MEM_ADDR !== 32'h500) n_bad++;
      if (INST_RVALID) n_iv++;
      prev_req = MEM_REQ;
      if (c == 5) begin
        #2 INST_RDEN = 0;
      end
    end
    cmp("t3_req_cycles", n_req, 4);
    cmp("t3_transactions", n_rise, 1);
    cmp("t3_addr_unstable", n_bad, 0);
    cmp("t3_inst_rvalids", n_iv, 1);

    // Flush of an in-flight fetch
    mem_delay = 2;
    #2 INST_RDEN = 1; INST_RIADDR = 32'h300;
    @(negedge CLK);
    cmp("t4_req_c1", MEM_REQ, 1);
    #2 INST_RDEN = 0;
    @(negedge CLK);
    #2 FLUSH = 1;
    @(negedge CLK);
    #2 FLUSH = 0;
    @(negedge CLK);
    mem_delay = 0;
    cmp("t4_ivalid_c4", INST_RVALID, 0);
    cmp("t4_req_c4", MEM_REQ, 0);
    @(negedge CLK);
    cmp("t4_ivalid_c5", INST_RVALID, 0);
    #2 INST_RDEN = 1; INST_RIADDR = 32'h400;
    @(negedge CLK);
    cmp("t4_new_addr", MEM_ADDR, 32'h400);
    #2 INST_RDEN = 0;
    @(negedge CLK);
    cmp("t4_new_ivalid", INST_RVALID, 1);
    cmp("t4_new_iroaddr", INST_ROADDR, 32'h400);
    repeat (2) @(negedge CLK);

    // Reset mid-transaction
    mem_delay = 5;
    #2 INST_RDEN = 1; INST_RIADDR = 32'h600;
    @(negedge CLK);
    #2 INST_RDEN = 0;
    @(negedge CLK);
    cmp("t5_req_before", MEM_REQ, 1);
    #3 RST = 0;
    #1;
    cmp("t5_req_in_rst", MEM_REQ, 0);
    cmp("t5_wait_in_rst", MEM_WAIT, 0);
    @(negedge CLK);
    #2 RST = 1;
    @(negedge CLK);
    force_ack = 1;
    @(negedge CLK);
    force_ack = 0;
    mem_delay = 0;
    @(negedge CLK);
    cmp("t5_ivalid_after", INST_RVALID, 0);
    cmp("t5_dvalid_after", DATA_RVALID, 0);
    cmp("t5_req_after", MEM_REQ, 0);
    repeat (2) @(negedge CLK);

    // Randomized traffic
    rand_mem = 1; stray = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      #2;
      DATA_WREN   = ($urandom_range(0, 3) == 0);
      DATA_WADDR  = $urandom;
      DATA_WDATA  = $urandom;
      DATA_RDEN   = ($urandom_range(0, 3) == 0);
      DATA_RIADDR = $urandom;
      INST_RDEN   = ($urandom_range(0, 1) == 0);
      INST_RIADDR = $urandom;
      FLUSH       = ($urandom_range(0, 11) == 0);
    end
    @(negedge CLK);
    #2;
    DATA_WREN = 0; DATA_RDEN = 0; INST_RDEN = 0; FLUSH = 0; stray = 0;
    repeat (30) @(negedge CLK);
    cmp("drain_wait", MEM_WAIT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
